// File: rtl/inst_loader.sv
// inst_loader: streams a length-prefixed, XOR-checksummed byte image into instruction memory
// and holds the core until the image loads cleanly.
module inst_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic              rx_rdy,
  output logic              wren,
  output logic [ADDR_W-3:0] wraddr,
  output logic [31:0]       wrdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN0 = 3'd1;
  localparam logic [2:0] LEN1 = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;
  localparam logic [16:0] DEPTH = 17'd1 << (ADDR_W - 2);
  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [1:0]        r_lane;
  logic [23:0]       r_word;
  logic [7:0]        r_csum;
  logic              r_wren;
  logic [ADDR_W-3:0] r_wraddr;
  logic [31:0]       r_wrdata;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
  logic              w_xfer;
  logic [15:0]       w_len;
  assign rx_rdy    = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA) || (r_state == CSUM);
  assign w_xfer    = rx_vld && rx_rdy;
  assign w_len     = {rx_data, r_len[7:0]};
  assign busy      = r_state != IDLE;
  assign wren      = r_wren;
  assign wraddr    = r_wraddr;
  assign wrdata    = r_wrdata;
  assign core_hold = r_hold;
  assign done      = r_done;
  assign error     = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_lane   <= '0;
      r_word   <= '0;
      r_csum   <= '0;
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_wrdata <= '0;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= LEN0;
          r_hold  <= 1'b1;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_lane  <= '0;
          r_csum  <= '0;
        end
        LEN0: if (w_xfer) begin
          r_len[7:0] <= rx_data;
          r_state    <= LEN1;
        end
        LEN1: if (w_xfer) begin
          r_len[15:8] <= rx_data;
          if ({1'b0, w_len} > DEPTH) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= (w_len == 16'd0) ? CSUM : DATA;
          end
        end
        DATA: if (w_xfer) begin
          r_csum <= r_csum ^ rx_data;
          r_lane <= r_lane + 2'd1;
          // the word goes out through the output register, so the stream never stalls on a write
          if (r_lane == 2'd3) begin
            r_wren   <= 1'b1;
            r_wraddr <= r_cnt[ADDR_W-3:0];
            r_wrdata <= {rx_data, r_word};
            r_cnt    <= r_cnt + 16'd1;
            if (r_cnt + 16'd1 == r_len) r_state <= CSUM;
          end else begin
            r_word[{r_lane, 3'b000} +: 8] <= rx_data;
          end
        end
        CSUM: if (w_xfer) begin
          r_state <= IDLE;
          if (rx_data == r_csum) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scenario tasks drive byte streams; a negedge monitor pops expected writes from a scoreboard.
module tb_inst_loader;
  typedef logic [7:0] bq_t[$];
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic        rx_rdy, wren, core_hold, busy, done, error;
  logic [9:0]  wraddr;
  logic [31:0] wrdata;
  logic [41:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_done = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  inst_loader #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_vld(rx_vld),
    .rx_rdy(rx_rdy), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [41:0] e;
    cyc++;
    if (wren) begin
      n_wr++;
      last_wr_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wren: got addr=%0d data=%h, required no write", wraddr, wrdata);
      end else begin
        e = sb.pop_front();
        if ({wraddr, wrdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", wraddr, wrdata, e[41:32], e[31:0]);
        end
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int gap);
    foreach (s[i]) begin
      int t = 0;
      rx_data = s[i];
      rx_vld  = 1'b1;
      while (!rx_rdy && t < 50) begin @(negedge clk); t++; end
      if (!rx_rdy) begin
        n_checks++; n_fail++;
        $display("FAIL rx_rdy_timeout: byte %0d rx_rdy=0, required 1", i);
      end
      @(posedge clk); #1;
      rx_vld = 1'b0;
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    n_checks++;
    if ({core_hold, rx_rdy, busy, done, error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got hold,rdy,busy,done,err=%b, required 10000", {core_hold, rx_rdy, busy, done, error});
    end
    n_checks++;
    if (n_wr !== 0 || wraddr !== 10'd0 || wrdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_write_port: got writes=%0d addr=%0d data=%h, required 0 0 0", n_wr, wraddr, wrdata);
    end
  endtask

  task automatic test_single();
    int w0 = n_wr, d0 = n_done;
    sb.push_back({10'd0, 32'h00A00513});
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: got busy=%b rdy=%b, required 1 1", busy, rx_rdy);
    end
    send_stream('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6}, 0);
    idle(3);
    n_checks++;
    if (n_wr - w0 !== 1 || n_done - d0 !== 1 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL single_counts: got writes=%0d dones=%0d pending=%0d, required 1 1 0", n_wr - w0, n_done - d0, sb.size());
    end
    n_checks++;
    if ({core_hold, error, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_status: got hold,err,busy=%b, required 000", {core_hold, error, busy});
    end
    n_checks++;
    if (!(last_wr_cyc < done_cyc)) begin
      n_fail++;
      $display("FAIL single_order: got wren cycle %0d done cycle %0d, required wren before done", last_wr_cyc, done_cyc);
    end
  endtask

  task automatic test_stall();
    int w0 = n_wr, d0 = n_done;
    for (int i = 0; i < 3; i++) sb.push_back({10'(i), {4{8'(8'h11 * (i + 1))}}});
    pulse_start();
    n_checks++;
    if (core_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL rehold: got core_hold=%b after start, required 1", core_hold);
    end
    send_stream('{8'h03, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                  8'h33, 8'h33, 8'h33, 8'h33, 8'h00}, 1);
    idle(3);
    n_checks++;
    if (n_wr - w0 !== 3 || n_done - d0 !== 1 || sb.size() !== 0 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_counts: got writes=%0d dones=%0d pending=%0d hold=%b, required 3 1 0 0", n_wr - w0, n_done - d0, sb.size(), core_hold);
    end
  endtask

  task automatic test_bad_csum();
    int w0 = n_wr, d0 = n_done;
    sb.push_back({10'd0, 32'h00A00513});
    pulse_start();
    send_stream('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00}, 0);
    idle(3);
    n_checks++;
    if (n_wr - w0 !== 1 || n_done - d0 !== 0 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL badcsum_counts: got writes=%0d dones=%0d pending=%0d, required 1 0 0", n_wr - w0, n_done - d0, sb.size());
    end
    n_checks++;
    if ({error, core_hold, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL badcsum_status: got err,hold,busy=%b, required 110", {error, core_hold, busy});
    end
  endtask

  task automatic test_overflow_and_empty();
    int w0 = n_wr, d0 = n_done;
    pulse_start();
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: got error=%b after start, required 0", error);
    end
    send_stream('{8'h01, 8'h04}, 0);
    idle(2);
    n_checks++;
    if ({error, busy, rx_rdy, core_hold} !== 4'b1001 || n_wr != w0) begin
      n_fail++;
      $display("FAIL overflow: got err,busy,rdy,hold=%b writes=%0d, required 1001 0", {error, busy, rx_rdy, core_hold}, n_wr - w0);
    end
    pulse_start();
    send_stream('{8'h00, 8'h00, 8'h00}, 0);
    idle(3);
    n_checks++;
    if (n_wr != w0 || n_done - d0 !== 1 || error !== 1'b0 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_load: got writes=%0d dones=%0d err=%b hold=%b, required 0 1 0 0", n_wr - w0, n_done - d0, error, core_hold);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = n_done;
    sb.push_back({10'd0, 32'h00A00513});
    pulse_start();
    send_stream('{8'h02, 8'h00, 8'h13, 8'h05}, 0);
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || rx_rdy !== 1'b1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start: got busy=%b rdy=%b err=%b, required 1 1 0", busy, rx_rdy, error);
    end
    send_stream('{8'hA0, 8'h00, 8'h11, 8'h22}, 0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({wren, core_hold, busy, rx_rdy, done, error} !== 6'b010000 || wraddr !== 10'd0 || wrdata !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got wren,hold,busy,rdy,done,err=%b addr=%0d data=%h, required 010000 0 0",
               {wren, core_hold, busy, rx_rdy, done, error}, wraddr, wrdata);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_pending: got %0d pending writes, required 0", sb.size());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    sb.push_back({10'd0, 32'h04030201});
    sb.push_back({10'd1, 32'h08070605});
    pulse_start();
    send_stream('{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08}, 0);
    idle(3);
    n_checks++;
    if (sb.size() !== 0 || n_done - d0 !== 1 || core_hold !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reload: got pending=%0d dones=%0d hold=%b err=%b, required 0 1 0 0", sb.size(), n_done - d0, core_hold, error);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_stall();
    test_bad_csum();
    test_overflow_and_empty();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
